// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the countdown timer array.
// Channel state encoding plus the saturating decrement used by every channel.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chan_state_e;

  // Widths are fixed at 32 so any DW up to 32 can share one helper.
  function automatic logic [31:0] sat_dec(input logic [31:0] value, input logic [31:0] step);
    return (value <= step) ? 32'd0 : value - step;
  endfunction

endpackage

// File: rtl/countdown_timer_chan.sv
// One count-down channel: IDLE -> RUN -> DONE -> IDLE, with elapsed-cycle timer.
// Define TIMER_SAT_EN to saturate the timer at all-ones instead of wrapping.
module countdown_timer_chan
  import countdown_timer_pkg::*;
#(
  parameter int DW   = 8,
  parameter int TW   = 8,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [DW-1:0] start_data_i,
  input  logic          ack_i,
  output logic          idle_o,
  output logic          req_o,
  output logic [TW-1:0] timer_o
);

  chan_state_e   state_q;
  logic [DW-1:0] data_q, data_d;
  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    data_d = DW'(sat_dec(32'(data_q), 32'(STEP)));
`ifdef TIMER_SAT_EN
    timer_d = (&timer_q) ? timer_q : timer_q + TW'(1);
`else
    timer_d = timer_q + TW'(1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          data_q  <= start_data_i;
          timer_q <= '0;
          state_q <= (start_data_i == '0) ? DONE : RUN;
        end
        // Leave RUN on the same edge that writes the final zero.
        RUN: begin
          data_q  <= data_d;
          timer_q <= timer_d;
          if (data_d == '0) state_q <= DONE;
        end
        DONE: if (ack_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idle_o  = (state_q == IDLE);
  assign req_o   = (state_q == DONE);
  assign timer_o = timer_q;

endmodule

// File: rtl/countdown_timer_array.sv
// NCH count-down channels with start decode, round-robin result arbiter and result mux.
// Results leave on a valid/ready port; the grant holds until accepted. Build option: TIMER_SAT_EN.
module countdown_timer_array
  import countdown_timer_pkg::*;
#(
  parameter  int NCH  = 4,
  parameter  int DW   = 8,
  parameter  int TW   = 8,
  parameter  int STEP = 1,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [CHW-1:0] start_ch,
  input  logic [DW-1:0]  start_data,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [CHW-1:0] res_ch,
  output logic [TW-1:0]  res_timer,
  output logic [NCH-1:0] busy
);

  logic [NCH-1:0] idle, req, start_hit, ack;
  logic [TW-1:0]  timer [NCH];
  logic [CHW-1:0] ptr_q, lock_ch_q, gnt, search_gnt;
  logic           lock_q, any_req, hs;
  int             idx;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    countdown_timer_chan #(.DW(DW), .TW(TW), .STEP(STEP)) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_hit[g]),
      .start_data_i (start_data),
      .ack_i        (ack[g]),
      .idle_o       (idle[g]),
      .req_o        (req[g]),
      .timer_o      (timer[g])
    );
  end

  // An out-of-range start_ch matches no channel, so start_ready stays low.
  always_comb begin
    start_ready = 1'b0;
    start_hit   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (start_ch == CHW'(i)) begin
        start_ready  = idle[i];
        start_hit[i] = start_valid & idle[i];
      end
    end
  end

  always_comb begin
    idx        = 0;
    any_req    = 1'b0;
    search_gnt = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(ptr_q) + k) % NCH;
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        search_gnt = CHW'(idx);
      end
    end
  end

  // A locked grant keeps its channel DONE, so any_req stays high while locked.
  assign gnt       = lock_q ? lock_ch_q : search_gnt;
  assign res_valid = any_req;
  assign hs        = res_valid & res_ready;
  assign res_ch    = res_valid ? gnt : '0;
  assign res_timer = res_valid ? timer[gnt] : '0;
  assign busy      = ~idle;

  always_comb begin
    ack = '0;
    for (int i = 0; i < NCH; i++) ack[i] = hs && (gnt == CHW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q <= res_valid & ~res_ready;
      if (res_valid & ~res_ready) lock_ch_q <= gnt;
      if (hs) ptr_q <= (gnt == CHW'(NCH - 1)) ? '0 : gnt + CHW'(1);
    end
  end

endmodule
